// File: rtl/baggage_drop_seq.sv
// baggage_drop_seq: latches sensors, averages, bit-serial sqrt, fall-time compare and timed drop/cooldown.
// Optional macro SENSOR_FAULT_EN: a zero sensor reading aborts to cooldown with a fault pulse.
module baggage_drop_seq #(
    parameter int DROP_CYCLES = 4,
    parameter int COOL_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  sensor1_i,
    input  logic [7:0]  sensor2_i,
    input  logic [7:0]  sensor3_i,
    input  logic [7:0]  sensor4_i,
    input  logic [15:0] t_lim_i,
    input  logic        drop_en_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] t_act_o,
    output logic        drop_activated_o,
    output logic        fault_o
);
    typedef enum logic [2:0] {IDLE, AVG, SQRT, CMP, DROP, COOL} state_t;
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d, rad_q, rad_d, t_act_q, t_act_d, t_new;
    logic [3:0][7:0] s_q, s_d;
    logic [9:0] rem_q, rem_d, sum;
    logic [7:0] root_q, root_d, height;
    logic [11:0] rem_sh, trial;
    logic done_q, done_d, fault_q, fault_d, ge, zero_hit;
    assign sum = {2'b00, s_q[0]} + {2'b00, s_q[1]} + {2'b00, s_q[2]} + {2'b00, s_q[3]};
    assign height = 8'(sum >> 2);
    // restoring sqrt: bring down two radicand bits, try subtracting (4*root + 1)
    assign rem_sh = {rem_q, rad_q[15:14]};
    assign trial = {2'b00, root_q, 2'b01};
    assign ge = rem_sh >= trial;
    assign t_new = {9'b0, root_q[7:1]};
`ifdef SENSOR_FAULT_EN
    assign zero_hit = (s_q[0] == 8'h00) || (s_q[1] == 8'h00) || (s_q[2] == 8'h00) || (s_q[3] == 8'h00);
`else
    assign zero_hit = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            t_act_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            t_act_q <= t_act_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        t_act_d = t_act_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                s_d     = {sensor4_i, sensor3_i, sensor2_i, sensor1_i};
                state_d = AVG;
            end
            AVG: begin
                cnt_d   = '0;
                rad_d   = {height, 8'h00};
                rem_d   = '0;
                root_d  = '0;
                fault_d = zero_hit;
                state_d = zero_hit ? COOL : SQRT;
            end
            SQRT: begin
                rad_d   = {rad_q[13:0], 2'b00};
                rem_d   = ge ? 10'(rem_sh - trial) : rem_sh[9:0];
                root_d  = {root_q[6:0], ge};
                cnt_d   = cnt_q + 16'd1;
                state_d = (cnt_q == 16'd7) ? CMP : SQRT;
            end
            CMP: begin
                t_act_d = t_new;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = (drop_en_i && t_new <= t_lim_i) ? DROP : COOL;
            end
            DROP: begin
                cnt_d   = (!drop_en_i || cnt_q == 16'(DROP_CYCLES - 1)) ? '0 : cnt_q + 16'd1;
                state_d = (!drop_en_i || cnt_q == 16'(DROP_CYCLES - 1)) ? COOL : DROP;
            end
            COOL: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = (cnt_q == 16'(COOL_CYCLES - 1)) ? IDLE : COOL;
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy_o = state_q != IDLE;
    assign drop_activated_o = state_q == DROP;
    assign done_o = done_q;
    assign fault_o = fault_q;
    assign t_act_o = t_act_q;
endmodule

// File: tb/tb_baggage_drop_seq.sv
// tb_baggage_drop_seq: directed vectors; expectations queued at start, checked by a done/busy monitor.
module tb_baggage_drop_seq;
    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, drop_en_i = 1'b0;
    logic [7:0] sensor1_i = '0, sensor2_i = '0, sensor3_i = '0, sensor4_i = '0;
    logic [15:0] t_lim_i = '0;
    logic busy_o, done_o, drop_activated_o, fault_o;
    logic [15:0] t_act_o;
    typedef struct {int t; int drop; int cyc;} exp_t;
    exp_t q[$];
    exp_t cur;
    int checks = 0, errors = 0, cyc = 0, busy_run = 0, drop_run = 0, fault_cnt = 0;
    bit trk = 0;
`ifdef SENSOR_FAULT_EN
    localparam int EXP_FAULT = 1;
`else
    localparam int EXP_FAULT = 0;
`endif

    baggage_drop_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .sensor1_i(sensor1_i), .sensor2_i(sensor2_i), .sensor3_i(sensor3_i), .sensor4_i(sensor4_i),
        .t_lim_i(t_lim_i), .drop_en_i(drop_en_i),
        .busy_o(busy_o), .done_o(done_o), .t_act_o(t_act_o),
        .drop_activated_o(drop_activated_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            trk = 0;
            busy_run = 0;
            drop_run = 0;
        end else begin
            if (fault_o) fault_cnt++;
            if (done_o) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    cur = q.pop_front();
                    trk = 1;
                    chk("t_act", int'(t_act_o), cur.t);
                    chk("done_cycle", cyc, cur.cyc);
                end
            end
            if (drop_activated_o) drop_run++;
            if (busy_o) busy_run++;
            else if (busy_run != 0) begin
                if (trk) begin
                    chk("drop_len", drop_run, cur.drop);
                    chk("busy_len", busy_run, 18 + cur.drop);
                    trk = 0;
                end
                busy_run = 0;
                drop_run = 0;
            end
        end
    end

    task automatic launch(input logic [7:0] a, b, c, d, input logic [15:0] lim, input logic en,
                          input int t, input int drop, input bit push);
        @(negedge clk);
        {sensor1_i, sensor2_i, sensor3_i, sensor4_i} = {a, b, c, d};
        t_lim_i = lim;
        drop_en_i = en;
        start_i = 1'b1;
        if (push) q.push_back(exp_t'{t, drop, cyc + 11});
        @(negedge clk);
        start_i = 1'b0;
        {sensor1_i, sensor2_i, sensor3_i, sensor4_i} = 32'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) chk("idle_timeout", 1, 0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_drop"}, int'(drop_activated_o), 0);
        chk({tag, "_fault"}, int'(fault_o), 0);
        chk({tag, "_t_act"}, int'(t_act_o), 0);
    endtask

    task automatic async_reset(string tag);
        #1 rst_n = 1'b0;
        #1 check_zero(tag);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        check_zero("reset");
        #2 rst_n = 1'b1;
        launch(8'd64, 8'd64, 8'd64, 8'd64, 16'd64, 1'b1, 64, 4, 1);
        wait_idle();
        launch(8'd64, 8'd64, 8'd64, 8'd64, 16'd63, 1'b1, 64, 0, 1);
        wait_idle();
        launch(8'd255, 8'd255, 8'd255, 8'd255, 16'hFFFF, 1'b1, 127, 4, 1);
        wait_idle();
`ifdef SENSOR_FAULT_EN
        launch(8'd0, 8'd0, 8'd0, 8'd4, 16'd8, 1'b1, 0, 0, 0);
        wait_idle();
        chk("t_act_held", int'(t_act_o), 127);
`else
        launch(8'd0, 8'd0, 8'd0, 8'd4, 16'd8, 1'b1, 8, 4, 1);
        wait_idle();
`endif
        launch(8'd10, 8'd20, 8'd30, 8'd41, 16'd100, 1'b0, 40, 0, 1);
        wait_idle();
        // abort on 2nd drop cycle, with stray start pulses while busy
        launch(8'd64, 8'd64, 8'd64, 8'd64, 16'd64, 1'b1, 64, 2, 1);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start_i = (i == 3 || i == 10);
        end
        drop_en_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle();
        launch(8'd64, 8'd64, 8'd64, 8'd64, 16'd64, 1'b1, 0, 0, 0);
        repeat (4) @(negedge clk);
        async_reset("rst_sqrt");
        launch(8'd255, 8'd255, 8'd255, 8'd255, 16'd200, 1'b1, 127, 4, 1);
        repeat (11) @(negedge clk);
        chk("drop_before_rst", int'(drop_activated_o), 1);
        async_reset("rst_drop");
        launch(8'd64, 8'd64, 8'd64, 8'd64, 16'd64, 1'b1, 64, 4, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("pending_expect", q.size(), 0);
        chk("fault_cnt", fault_cnt, EXP_FAULT);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
